// File: rtl/bram_bank_loader_if.sv
// bram_bank_loader_if: load control, input word stream and per-bank port-A write bundle.
interface bram_bank_loader_if #(
    parameter int BANKS = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int ADDR  = $clog2(DEPTH),
    parameter int WE    = WIDTH / 8
);
    logic                   start;
    logic [ADDR-1:0]        base_addr;
    logic [ADDR:0]          rows;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [WIDTH-1:0]       s_tdata;
    logic                   s_tvalid;
    logic                   s_tready;
    logic                   s_tlast;
    logic [BANKS-1:0]       ena;
    logic [BANKS*WE-1:0]    wea;
    logic [BANKS*ADDR-1:0]  addra;
    logic [BANKS*WIDTH-1:0] dina;

    modport master (
        output start, base_addr, rows, s_tdata, s_tvalid, s_tlast,
        input  busy, done, error, s_tready, ena, wea, addra, dina
    );
    modport slave (
        input  start, base_addr, rows, s_tdata, s_tvalid, s_tlast,
        output busy, done, error, s_tready, ena, wea, addra, dina
    );
endinterface

// File: rtl/bram_bank_loader.sv
// bram_bank_loader: scatters a word stream round-robin over BRAM banks, one row per bank sweep.
module bram_bank_loader #(
    parameter int BANKS = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int ADDR  = $clog2(DEPTH),
    parameter int WE    = WIDTH / 8
) (
    input logic clk,
    input logic rst,
    bram_bank_loader_if.slave bus
);
    localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t                 state;
    logic [ADDR-1:0]        base;
    logic [ADDR:0]          rows_q;
    logic [BW-1:0]          bank;
    logic [ADDR-1:0]        row_ofs;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [BANKS-1:0]       ena;
    logic [BANKS*WE-1:0]    wea;
    logic [BANKS*ADDR-1:0]  addra;
    logic [BANKS*WIDTH-1:0] dina;
    logic                   last_bank;
    logic                   last;
    assign last_bank    = bank == BW'(BANKS - 1);
    assign last         = last_bank && {1'b0, row_ofs} == rows_q - (ADDR + 1)'(1);
    assign bus.busy     = busy;
    assign bus.s_tready = busy;
    assign bus.done     = done;
    assign bus.error    = error;
    assign bus.ena      = ena;
    assign bus.wea      = wea;
    assign bus.addra    = addra;
    assign bus.dina     = dina;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            rows_q  <= '0;
            bank    <= '0;
            row_ofs <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            ena     <= '0;
            wea     <= '0;
            addra   <= '0;
            dina    <= '0;
        end else begin
            ena  <= '0;
            wea  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    error <= 1'b0;
                    if (bus.rows != '0) begin
                        base    <= bus.base_addr;
                        rows_q  <= bus.rows;
                        bank    <= '0;
                        row_ofs <= '0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                LOAD: if (bus.s_tvalid) begin
                    ena[bank]                   <= 1'b1;
                    wea[bank*WE +: WE]          <= '1;
                    addra[bank*ADDR +: ADDR]    <= base + row_ofs;
                    dina[bank*WIDTH +: WIDTH]   <= bus.s_tdata;
                    // a premature tlast aborts the load; a missing one on the final word is flagged
                    if (last || bus.s_tlast) begin
                        error <= !(last && bus.s_tlast);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        bank <= last_bank ? '0 : bank + BW'(1);
                        if (last_bank) row_ofs <= row_ofs + ADDR'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_bank_loader.sv
// tb_bram_bank_loader: directed and randomized loads checked against a word-index address model.
module tb_bram_bank_loader;
    localparam int BANKS = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int ADDR  = 8;
    localparam int WE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bram_bank_loader_if #(.BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    bram_bank_loader #(.BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ena"}, bus.ena, 0);
        chk({tag, "_wea"}, bus.wea, 0);
        chk({tag, "_addra"}, bus.addra, 0);
        chk({tag, "_dina"}, bus.dina, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ready"}, bus.s_tready, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_error"}, bus.error, 0);
    endtask

    // Word n of a load lands in bank n%BANKS at row (base + n/BANKS) mod DEPTH.
    task automatic do_load(input int base, input int nrows, input int tlast_at, input bit gaps, input bit seqd);
        int total, n, cyc, b, r;
        bit ended, v, lst, experr;
        logic [WIDTH-1:0] d;
        total  = nrows * BANKS;
        experr = 0;
        bus.start     = 1'b1;
        bus.base_addr = base[ADDR-1:0];
        bus.rows      = nrows[ADDR:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_error", bus.error, 0);
        chk("start_busy", bus.busy, nrows != 0);
        chk("start_done", bus.done, nrows == 0);
        if (nrows == 0) begin
            chk("zero_ena", bus.ena, 0);
            @(posedge clk); #1;
            chk("zero_done_end", bus.done, 0);
            chk("zero_busy", bus.busy, 0);
            return;
        end
        n = 0;
        ended = 0;
        cyc = 0;
        while (!ended && cyc < 200) begin
            v   = gaps ? (cyc % 2 == 1) : 1'b1;
            d   = seqd ? WIDTH'(16'h10 + n) : WIDTH'($urandom);
            lst = v && (n == tlast_at);
            bus.s_tvalid = v;
            bus.s_tdata  = d;
            bus.s_tlast  = lst;
            chk("ready", bus.s_tready, 1);
            @(posedge clk); #1;
            bus.s_tvalid = 1'b0;
            bus.s_tlast  = 1'b0;
            if (v) begin
                b = n % BANKS;
                r = (base + n / BANKS) % DEPTH;
                chk("ena", bus.ena, 64'(1) << b);
                chk("wea", bus.wea, 64'(3) << (WE * b));
                chk("addra", bus.addra[b*ADDR +: ADDR], r);
                chk("dina", bus.dina[b*WIDTH +: WIDTH], d);
                ended = (n == total - 1) || lst;
                chk("done", bus.done, ended);
                chk("busy", bus.busy, !ended);
                if (ended) begin
                    experr = !(n == total - 1 && lst);
                    chk("error", bus.error, experr);
                end
                n++;
            end else begin
                chk("idle_ena", bus.ena, 0);
                chk("idle_wea", bus.wea, 0);
                chk("idle_done", bus.done, 0);
            end
            cyc++;
        end
        if (!ended) chk("timeout", ended, 1);
        @(posedge clk); #1;
        chk("after_done", bus.done, 0);
        chk("after_busy", bus.busy, 0);
        chk("after_ena", bus.ena, 0);
        chk("sticky_error", bus.error, experr);
    endtask

    initial begin
        int rr;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.rows      = '0;
        bus.s_tdata   = '0;
        bus.s_tvalid  = 1'b0;
        bus.s_tlast   = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 0);
        do_load(0, 2, 7, 0, 1);
        do_load(255, 2, 7, 0, 0);
        do_load(3, 1, 3, 1, 0);
        do_load(10, 1, 2, 0, 0);
        do_load(20, 1, 99, 0, 0);
        do_load(5, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            rr = int'($urandom_range(1, 3));
            do_load(int'($urandom_range(0, 255)), rr, int'($urandom_range(0, rr * BANKS - 1)), 1'($urandom), 0);
        end
        bus.start     = 1'b1;
        bus.base_addr = 8'h40;
        bus.rows      = 9'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", bus.busy, 1);
        bus.s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_load(8'h40, 1, 3, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
